// File: rtl/dmem_port_arbiter_pkg.sv
// Shared constants and owner encoding for the data-memory port arbiter.
package dmem_port_arbiter_pkg;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;
  localparam int unsigned WAIT_W    = 4;

  typedef enum logic {
    OWNER_P0 = 1'b0,
    OWNER_P1 = 1'b1
  } owner_e;

endpackage

// File: rtl/dmem_grant_select.sv
// Combinational grant selection for the two memory requesters.
module dmem_grant_select
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              mode,
  input  logic              p0_req,
  input  logic              p1_req,
  input  logic              last_owner,
  input  logic [WAIT_W-1:0] wait_cnt,
  output logic              p0_gnt,
  output logic              p1_gnt
);

  logic p1_wins;

  // On a tie: round-robin favours the port that did not own last; fixed mode
  // favours p0 until p1 has waited MAX_WAIT cycles.
  always_comb begin
    p0_gnt  = 1'b0;
    p1_gnt  = 1'b0;
    p1_wins = 1'b0;
    if (p0_req && p1_req) begin
      if (mode == 1'(ARB_RR)) begin
        p1_wins = (last_owner == OWNER_P0);
      end else begin
        p1_wins = (wait_cnt == WAIT_W'(MAX_WAIT));
      end
      p0_gnt = ~p1_wins;
      p1_gnt = p1_wins;
    end else begin
      p0_gnt = p0_req;
      p1_gnt = p1_req;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of the single-port data memory with a
// one-cycle registered read response per port.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ARB_MODE = 0,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data
);

  owner_e            owner_q, owner_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              sel_p0_gnt, sel_p1_gnt;

  dmem_grant_select #(
    .MAX_WAIT (MAX_WAIT)
  ) u_grant_select (
    .mode       (1'(ARB_MODE)),
    .p0_req     (p0_req),
    .p1_req     (p1_req),
    .last_owner (owner_q),
    .wait_cnt   (wait_q),
    .p0_gnt     (sel_p0_gnt),
    .p1_gnt     (sel_p1_gnt)
  );

  // No access may reach the memory while reset is held.
  assign p0_gnt = sel_p0_gnt & rst_n;
  assign p1_gnt = sel_p1_gnt & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWNER_P1;
    end else begin
      owner_q <= owner_d;
    end
  end

  always_comb begin
    owner_d = owner_q;
    if (p0_gnt) begin
      owner_d = OWNER_P0;
    end else if (p1_gnt) begin
      owner_d = OWNER_P1;
    end
  end

  // Consecutive-denial counter for p1, saturating at MAX_WAIT.
  always_comb begin
    wait_d = '0;
    if (p1_req && !p1_gnt) begin
      wait_d = (wait_q == WAIT_W'(MAX_WAIT)) ? wait_q : wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

  always_comb begin
    mem_address    = '0;
    mem_write_data = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    if (rst_n) begin
      if (p1_gnt) begin
        mem_address    = p1_addr;
        mem_write_data = p1_wdata;
      end else begin
        mem_address    = p0_addr;
        mem_write_data = p0_wdata;
      end
      mem_read  = (p0_gnt & ~p0_we) | (p1_gnt & ~p1_we);
      mem_write = (p0_gnt & p0_we) | (p1_gnt & p1_we);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      p0_rvalid <= p0_gnt & ~p0_we;
      p1_rvalid <= p1_gnt & ~p1_we;
      if (p0_gnt && !p0_we) begin
        p0_rdata <= mem_read_data;
      end
      if (p1_gnt && !p1_we) begin
        p1_rdata <= mem_read_data;
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: fixed-priority and round-robin instances
// checked cycle by cycle against a rule-level reference model.
module tb_dmem_port_arbiter;

  localparam int unsigned AW = 7;
  localparam int unsigned DW = 32;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic fill;
  always #5 clk = ~clk;

  logic          p0_req [2], p0_we [2], p1_req [2], p1_we [2];
  logic [AW-1:0] p0_addr [2], p1_addr [2];
  logic [DW-1:0] p0_wdata [2], p1_wdata [2];
  logic          p0_gnt [2], p1_gnt [2], p0_rvalid [2], p1_rvalid [2];
  logic [DW-1:0] p0_rdata [2], p1_rdata [2];
  logic [AW-1:0] maddr [2];
  logic [DW-1:0] mwd [2], mrd [2];
  logic          mrd_en [2], mwr [2];
  logic [DW-1:0] mem [2][128];

  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0), .MAX_WAIT(MW)) u_fixed (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req[0]), .p0_we(p0_we[0]), .p0_addr(p0_addr[0]), .p0_wdata(p0_wdata[0]),
    .p0_gnt(p0_gnt[0]), .p0_rvalid(p0_rvalid[0]), .p0_rdata(p0_rdata[0]),
    .p1_req(p1_req[0]), .p1_we(p1_we[0]), .p1_addr(p1_addr[0]), .p1_wdata(p1_wdata[0]),
    .p1_gnt(p1_gnt[0]), .p1_rvalid(p1_rvalid[0]), .p1_rdata(p1_rdata[0]),
    .mem_address(maddr[0]), .mem_write_data(mwd[0]), .mem_read(mrd_en[0]),
    .mem_write(mwr[0]), .mem_read_data(mrd[0]));

  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1), .MAX_WAIT(MW)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req[1]), .p0_we(p0_we[1]), .p0_addr(p0_addr[1]), .p0_wdata(p0_wdata[1]),
    .p0_gnt(p0_gnt[1]), .p0_rvalid(p0_rvalid[1]), .p0_rdata(p0_rdata[1]),
    .p1_req(p1_req[1]), .p1_we(p1_we[1]), .p1_addr(p1_addr[1]), .p1_wdata(p1_wdata[1]),
    .p1_gnt(p1_gnt[1]), .p1_rvalid(p1_rvalid[1]), .p1_rdata(p1_rdata[1]),
    .mem_address(maddr[1]), .mem_write_data(mwd[1]), .mem_read(mrd_en[1]),
    .mem_write(mwr[1]), .mem_read_data(mrd[1]));

  function automatic logic [DW-1:0] init_val(input int a);
    return DW'(32'h9E3779B9 * (a + 1));
  endfunction

  // Behavioural data memory, one per instance, combinational read.
  always @(posedge clk) begin
    if (fill) begin
      for (int m = 0; m < 2; m++)
        for (int a = 0; a < 128; a++) mem[m][a] <= init_val(a);
    end else begin
      if (mwr[0]) mem[0][maddr[0]] <= mwd[0];
      if (mwr[1]) mem[1][maddr[1]] <= mwd[1];
    end
  end
  assign mrd[0] = mem[0][maddr[0]];
  assign mrd[1] = mem[1][maddr[1]];

  // Reference model state (instance 0 = fixed priority, 1 = round-robin).
  int            last_g [2];
  int            waitc [2];
  bit            e_rv0 [2], e_rv1 [2];
  logic [DW-1:0] e_rd0 [2], e_rd1 [2];
  logic [DW-1:0] refmem [2][128];
  bit            g0 [2], g1 [2];
  bit            rst_hit;
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string tag, input int m, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[m%0d] observed=%h expected=%h", tag, m, obs, exp);
    end
  endtask

  task automatic model_reset(input int m);
    last_g[m] = 1; waitc[m] = 0;
    e_rv0[m] = 0; e_rv1[m] = 0; e_rd0[m] = '0; e_rd1[m] = '0;
  endtask

  task automatic predict(input int m);
    bit p1_turn;
    g0[m] = 0; g1[m] = 0;
    if (rst_n) begin
      if (p0_req[m] && p1_req[m]) begin
        p1_turn = (m == 0) ? (waitc[m] >= MW) : (last_g[m] == 0);
        g1[m] = p1_turn; g0[m] = !p1_turn;
      end else begin
        g0[m] = p0_req[m]; g1[m] = p1_req[m];
      end
    end
  endtask

  task automatic commit(input int m);
    if (!rst_n || rst_hit) begin
      model_reset(m);
      return;
    end
    e_rv0[m] = g0[m] && !p0_we[m];
    e_rv1[m] = g1[m] && !p1_we[m];
    if (e_rv0[m]) e_rd0[m] = refmem[m][p0_addr[m]];
    if (e_rv1[m]) e_rd1[m] = refmem[m][p1_addr[m]];
    if (g0[m] && p0_we[m]) refmem[m][p0_addr[m]] = p0_wdata[m];
    if (g1[m] && p1_we[m]) refmem[m][p1_addr[m]] = p1_wdata[m];
    if (g0[m]) last_g[m] = 0;
    else if (g1[m]) last_g[m] = 1;
    if (p1_req[m] && !g1[m]) waitc[m] = (waitc[m] < MW) ? waitc[m] + 1 : MW;
    else waitc[m] = 0;
  endtask

  // Called at a falling edge with inputs driven; checks the cycle, then
  // advances to the next falling edge. kill drops rst_n before the capture edge.
  task automatic step(input bit kill = 1'b0);
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    bit            er, ew;
    #1;
    for (int m = 0; m < 2; m++) begin
      predict(m);
      ea = '0; ed = '0; er = 0; ew = 0;
      if (rst_n) begin
        ea = g1[m] ? p1_addr[m] : p0_addr[m];
        ed = g1[m] ? p1_wdata[m] : p0_wdata[m];
        er = (g0[m] && !p0_we[m]) || (g1[m] && !p1_we[m]);
        ew = (g0[m] && p0_we[m]) || (g1[m] && p1_we[m]);
      end
      chk("p0_gnt", m, DW'(p0_gnt[m]), DW'(g0[m]));
      chk("p1_gnt", m, DW'(p1_gnt[m]), DW'(g1[m]));
      chk("mem_read", m, DW'(mrd_en[m]), DW'(er));
      chk("mem_write", m, DW'(mwr[m]), DW'(ew));
      chk("mem_address", m, DW'(maddr[m]), DW'(ea));
      chk("mem_write_data", m, mwd[m], ed);
      chk("p0_rvalid", m, DW'(p0_rvalid[m]), rst_n ? DW'(e_rv0[m]) : '0);
      chk("p1_rvalid", m, DW'(p1_rvalid[m]), rst_n ? DW'(e_rv1[m]) : '0);
      chk("p0_rdata", m, p0_rdata[m], rst_n ? e_rd0[m] : '0);
      chk("p1_rdata", m, p1_rdata[m], rst_n ? e_rd1[m] : '0);
    end
    if (kill) begin
      rst_n = 1'b0;
      rst_hit = 1'b1;
    end
    @(negedge clk);
    for (int m = 0; m < 2; m++) commit(m);
    rst_hit = 1'b0;
  endtask

  task automatic drv(input int m, input bit r0, input bit w0, input int a0,
                     input logic [DW-1:0] d0, input bit r1, input bit w1,
                     input int a1, input logic [DW-1:0] d1);
    p0_req[m] = r0; p0_we[m] = w0; p0_addr[m] = AW'(a0); p0_wdata[m] = d0;
    p1_req[m] = r1; p1_we[m] = w1; p1_addr[m] = AW'(a1); p1_wdata[m] = d1;
  endtask

  task automatic drv_both(input bit r0, input bit w0, input int a0, input logic [DW-1:0] d0,
                          input bit r1, input bit w1, input int a1, input logic [DW-1:0] d1);
    drv(0, r0, w0, a0, d0, r1, w1, a1, d1);
    drv(1, r0, w0, a0, d0, r1, w1, a1, d1);
  endtask

  initial begin
    int n_p1 [2];
    rst_n = 1'b0; fill = 1'b1; rst_hit = 1'b0;
    for (int m = 0; m < 2; m++) begin
      model_reset(m);
      g0[m] = 0; g1[m] = 0;
      for (int a = 0; a < 128; a++) refmem[m][a] = init_val(a);
    end
    drv_both(1, 1, 3, 32'h1111_1111, 1, 1, 4, 32'h2222_2222);
    @(negedge clk);

    // Reset held with both ports requesting writes.
    step(); step();
    fill = 1'b0; rst_n = 1'b1;
    drv_both(0, 0, 0, '0, 0, 0, 0, '0);
    step();

    // Single port: p1 write then read of address 5.
    drv_both(0, 0, 0, '0, 1, 1, 5, 32'hDEAD_BEEF);
    step();
    drv_both(0, 0, 0, '0, 1, 0, 5, '0);
    step();
    for (int m = 0; m < 2; m++) begin
      chk("p1_rvalid_after_read", m, DW'(p1_rvalid[m]), 32'd1);
      chk("p1_rdata_deadbeef", m, p1_rdata[m], 32'hDEAD_BEEF);
    end
    drv_both(0, 0, 0, '0, 0, 0, 0, '0);
    step();

    // Continuous tie of reads: p0 addr 1, p1 addr 2.
    drv_both(1, 0, 1, '0, 1, 0, 2, '0);
    n_p1[0] = 0; n_p1[1] = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      for (int m = 0; m < 2; m++) if (p1_gnt[m]) n_p1[m]++;
      step();
    end
    chk("fixed_p1_grants_in_10", 0, DW'(n_p1[0]), 32'd2);
    chk("rr_p1_grants_in_10", 1, DW'(n_p1[1]), 32'd5);
    drv_both(0, 0, 0, '0, 0, 0, 0, '0);
    step();

    // Cross-port write-then-read of address 9.
    drv_both(1, 1, 9, 32'h1234_5678, 0, 0, 0, '0);
    step();
    drv_both(0, 0, 0, '0, 1, 0, 9, '0);
    step();
    for (int m = 0; m < 2; m++) chk("p1_rdata_hazard", m, p1_rdata[m], 32'h1234_5678);

    // Reset lands on a read grant: its rvalid must never appear.
    drv_both(1, 0, 9, '0, 0, 0, 0, '0);
    step(1'b1);
    for (int m = 0; m < 2; m++) chk("p0_rvalid_killed", m, DW'(p0_rvalid[m]), 32'd0);
    step();
    rst_n = 1'b1;
    // Write whose grant cycle overlaps reset is dropped.
    drv_both(1, 1, 20, 32'hCAFE_F00D, 0, 0, 0, '0);
    step(1'b1);
    rst_n = 1'b1;
    drv_both(1, 0, 20, '0, 0, 0, 0, '0);
    step();
    for (int m = 0; m < 2; m++) chk("p0_rdata_dropped_write", m, p0_rdata[m], init_val(20));
    drv_both(0, 0, 0, '0, 1, 0, 9, '0);
    step();
    for (int m = 0; m < 2; m++) chk("p1_rdata_post_reset", m, p1_rdata[m], 32'h1234_5678);

    // Random traffic; an ungranted request keeps its fields until granted.
    for (int i = 0; i < 600; i++) begin
      for (int m = 0; m < 2; m++) begin
        if (!(p0_req[m] && !g0[m])) begin
          p0_req[m] = ($urandom_range(0, 3) != 0);
          p0_we[m] = 1'($urandom_range(0, 1));
          p0_addr[m] = AW'($urandom_range(0, 15));
          p0_wdata[m] = $urandom;
        end
        if (!(p1_req[m] && !g1[m])) begin
          p1_req[m] = ($urandom_range(0, 2) != 0);
          p1_we[m] = 1'($urandom_range(0, 1));
          p1_addr[m] = AW'($urandom_range(0, 15));
          p1_wdata[m] = $urandom;
        end
      end
      rst_n = ($urandom_range(0, 99) != 0);
      step($urandom_range(0, 149) == 0);
    end
    rst_n = 1'b1;
    drv_both(0, 0, 0, '0, 0, 0, 0, '0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
